// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with single-cycle arithmetic and a serial 1-bit/cycle shifter
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [3:0]      i_ALUCtrl,
    input  logic [XLEN-1:0] i_srcA,
    input  logic [XLEN-1:0] i_srcB,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero,
    output logic            o_busy
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [1:0]      kind_q, kind_d;
    logic            accept;
    logic            is_shift;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] shift_step;

    assign shamt    = i_srcB[SHW-1:0];
    assign is_shift = (i_ALUCtrl == 4'b0101) || (i_ALUCtrl == 4'b0110) || (i_ALUCtrl == 4'b0111);
    assign o_result = result_q;
    assign o_zero   = (result_q == '0);

    always_comb begin
        alu_out = i_srcA + i_srcB;
        case (i_ALUCtrl)
            4'b0001: alu_out = i_srcA - i_srcB;
            4'b0010: alu_out = i_srcA | i_srcB;
            4'b0011: alu_out = i_srcA & i_srcB;
            4'b0100: alu_out = i_srcA ^ i_srcB;
            4'b1101: alu_out = {{(XLEN-1){1'b0}}, ($signed(i_srcA) < $signed(i_srcB))};
            4'b1110: alu_out = {{(XLEN-1){1'b0}}, (i_srcA < i_srcB)};
            default: alu_out = i_srcA + i_srcB;
        endcase
    end

    // The result register doubles as the shift register; kind_q holds opcode[1:0].
    always_comb begin
        case (kind_q)
            2'b01:   shift_step = {result_q[XLEN-1], result_q[XLEN-1:1]};
            2'b10:   shift_step = {1'b0, result_q[XLEN-1:1]};
            default: shift_step = {result_q[XLEN-2:0], 1'b0};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        kind_d   = kind_q;
        o_ready  = 1'b0;
        o_valid  = 1'b0;
        o_busy   = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
            end
            SHIFT: begin
                o_busy   = 1'b1;
                result_d = shift_step;
                cnt_d    = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                o_ready = i_ready;
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (i_rst) begin
            o_ready = 1'b0;
        end
        accept = i_valid & o_ready;
        if (accept) begin
            kind_d = i_ALUCtrl[1:0];
            if (is_shift && (shamt != '0)) begin
                result_d = i_srcA;
                cnt_d    = shamt;
                state_d  = SHIFT;
            end else if (is_shift) begin
                result_d = i_srcA;
                state_d  = DONE;
            end else begin
                result_d = alu_out;
                state_d  = DONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            cnt_q    <= '0;
            kind_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            kind_q   <= kind_d;
        end
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code from the ALU control decoder, plus two operands from the register-read/immediate mux.
- Add, sub, logic and compare ops complete in one cycle.
- Shifts (sll/srl/sra) run through a serial 1-bit-per-cycle shifter to save area.
- Valid/ready handshakes on both sides let the pipeline stall while a shift is in progress.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  operands and control present.
- o_ready  output  1  unit can accept an operation this cycle.
- i_ALUCtrl  input  4  operation code.
- i_srcA  input  XLEN  operand A.
- i_srcB  input  XLEN  operand B; shift amount is i_srcB[SHW-1:0].
- o_valid  output  1  result available.
- i_ready  input  1  downstream accepts result.
- o_result  output  XLEN  result.
- o_zero  output  1  (o_result == 0); used for branch resolution.
- o_busy  output  1  high while in SHIFT state (hazard/stall hint).

Behaviour:
- Opcode map (fixed):
  - 0000 add: A+B, mod 2^XLEN.
  - 0001 sub: A-B, mod 2^XLEN.
  - 0010 or.
  - 0011 and.
  - 0100 xor.
  - 0101 sra.
  - 0110 srl.
  - 0111 sll.
  - 1101 slt: signed compare, result 1/0 zero-extended.
  - 1110 sltu: unsigned compare.
  - Any other code: treated as add.
- Accept: transfer occurs on a cycle with i_valid & o_ready. Operands and code are captured at that edge; later input changes have no effect.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - o_ready=1, o_valid=0.
  - On accept of a non-shift op: result registered, go to DONE.
  - On accept of a shift op with shamt=0: result=A, go to DONE.
  - On accept of a shift op with shamt>0: load A into the shift register and shamt into the down-counter, go to SHIFT.
- SHIFT:
  - o_ready=0, o_busy=1.
  - Each cycle, shift 1 bit (sll: zero-fill LSB; srl: zero-fill MSB; sra: replicate MSB) and decrement the counter.
  - When counter reaches 1, that final shift completes; go to DONE.
  - Total SHIFT cycles = shamt.
- DONE:
  - o_valid=1; o_result and o_zero held stable until taken.
  - Transfer on o_valid & i_ready.
  - o_ready = i_ready, so back-to-back issue is allowed.
  - If i_ready & i_valid: accept the new op in the same cycle, then go to DONE or SHIFT per the IDLE rules.
  - If i_ready & !i_valid: go to IDLE.
  - If !i_ready: stay in DONE; no new accept.
- Latency, accept edge T to o_valid:
  - Non-shift or shamt=0: o_valid at T+1.
  - Shift: o_valid at T+1+shamt.
  - Maximum is XLEN cycles (shamt=XLEN-1).
- Throughput: one non-shift op per cycle when i_ready is held high.
- Reset:
  - Values: state=IDLE, o_valid=0, o_busy=0, o_result=0, o_zero=1, counter=0; o_ready=1 in the cycle after reset deasserts.
  - While i_rst=1, o_ready=0 and no accept occurs.
  - Reset mid-shift or in DONE aborts the operation; the result is discarded.
- Only shamt bits [SHW-1:0] are used; upper bits of i_srcB are ignored for shifts.
- No X propagation: o_result is registered in every state.

Test Plan:
- Reset, then ALUCtrl=0001, A=5, B=7, downstream ready -> o_valid one cycle after accept; o_result=0xFFFFFFFE; o_zero=0.
- Back-to-back ops with i_ready=1:
  - add 3+4 -> 7, then sub 9-9 -> 0 with o_zero=1, then slt A=0xFFFFFFFF, B=1 -> 1, then sltu same operands -> 0.
  - Issued on consecutive cycles; o_ready never drops; results on consecutive cycles.
- Shift latencies:
  - sra A=0x80000000, B=4 -> o_busy for 4 cycles, o_valid at T+5, o_result=0xF8000000.
  - srl same operands -> 0x08000000.
  - sll A=1, B=0x25 (shamt=5) -> 0x20.
  - shamt=0 -> o_result=A at T+1.
- Backpressure: hold i_ready=0 for 3 cycles in DONE with i_valid=1 -> o_result/o_valid stable, o_ready=0, no accept; release -> pending op accepted on the release cycle.
- Assert i_rst during SHIFT (sll shamt=31, cycle 10) -> next cycle o_valid=0, o_busy=0, o_result=0; a fresh add 1+1 -> 2 after reset.
- Undefined code 1010 with A=2, B=3 -> o_result=5.
